// File: rtl/shared_reg_arbiter_pkg.sv
// Shared state register arbiter: common types and defaults.
// One owner at a time writes the shared register.
package shared_reg_arb_pkg;

  localparam int N_REQ_DEF    = 4;
  localparam int WIDTH_DEF    = 4;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Round-robin selector: first set request bit
// scanning upward from ptr, wrapping at N_REQ-1.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         Req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     found
);

  localparam int IW = $clog2(N_REQ);

  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && Req[idx[IW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for a
// single shared register, with bounded lock hold.
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                     Clk,
  input  logic                     Rst_l,
  input  logic [N_REQ-1:0]         Req,
  input  logic [N_REQ-1:0]         Lock,
  input  logic [N_REQ*WIDTH-1:0]   Data,
  output logic [N_REQ-1:0]         Gnt,
  output logic [N_REQ-1:0]         Ack,
  output logic [WIDTH-1:0]         Q,
  output logic [$clog2(N_REQ)-1:0] Owner,
  output logic                     Busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_HOLD + 2);
  localparam logic [N_REQ-1:0] ONE =
    {{(N_REQ-1){1'b0}}, 1'b1};

  arb_state_e state_q, state_d;

  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [CW-1:0]    hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [WIDTH-1:0] q_q, q_d;

  logic [IW-1:0] winner;
  logic          found;
  logic          wr, lk, hold_done;
  logic [CW-1:0] hold_inc;
  logic [IW-1:0] ptr_nxt;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .Req    (Req),
    .ptr    (ptr_q),
    .winner (winner),
    .found  (found)
  );

  assign wr        = (state_q != IDLE) && Req[owner_q];
  assign lk        = Lock[owner_q];
  assign hold_inc  = hold_q + CW'(1);
  assign hold_done = !lk || (hold_inc >= CW'(MAX_HOLD));
  assign ptr_nxt   = (owner_q == IW'(N_REQ-1)) ?
                     '0 : owner_q + IW'(1);

  always_ff @(posedge Clk or negedge Rst_l) begin
    if (!Rst_l) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = GRANT;
      GRANT:   state_d = (wr && lk) ? HOLD : IDLE;
      HOLD:    if (hold_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    q_d     = q_q;
    if (state_q == IDLE) begin
      if (found) begin
        gnt_d   = ONE << winner;
        owner_d = winner;
      end
    end else begin
      if (wr) begin
        q_d   = Data[owner_q*WIDTH +: WIDTH];
        ack_d = ONE << owner_q;
      end
      // an idle owner still burns hold budget
      hold_d = (state_q == GRANT) ? CW'(1) : hold_inc;
      if (state_d == IDLE) begin
        gnt_d = '0;
        ptr_d = ptr_nxt;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_l) begin
    if (!Rst_l) begin
      ptr_q   <= '0;
      owner_q <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
    end
  end

  assign Gnt   = gnt_q;
  assign Ack   = ack_q;
  assign Q     = q_q;
  assign Owner = owner_q;
  assign Busy  = (state_q != IDLE);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed scenarios
// plus random traffic against a behavioural model.
module tb_shared_reg_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int MH = 8;

  logic          Clk = 1'b0;
  logic          Rst_l;
  logic [N-1:0]  Req, Lock;
  logic [N*W-1:0] Data;
  logic [N-1:0]  Gnt, Ack;
  logic [W-1:0]  Q;
  logic [1:0]    Owner;
  logic          Busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  shared_reg_arbiter #(
    .N_REQ(N), .WIDTH(W), .MAX_HOLD(MH)
  ) dut (
    .Clk   (Clk),
    .Rst_l (Rst_l),
    .Req   (Req),
    .Lock  (Lock),
    .Data  (Data),
    .Gnt   (Gnt),
    .Ack   (Ack),
    .Q     (Q),
    .Owner (Owner),
    .Busy  (Busy)
  );

  // model: owner index (-1 = none), first write pending,
  // writes/cycles used in this tenure, rotation start
  int         m_own;
  bit         m_first;
  int         m_cnt;
  int         m_ptr;
  logic [3:0] m_q;
  logic [3:0] exp_ack;

  function automatic logic [3:0] m_gnt();
    if (m_own < 0) return 4'b0;
    return 4'(1 << m_own);
  endfunction

  task automatic model_reset();
    m_own = -1; m_first = 0; m_cnt = 0;
    m_ptr = 0;  m_q = '0;    exp_ack = '0;
  endtask

  task automatic step();
    bit w, rel;
    int c;
    @(posedge Clk);
    exp_ack = '0;
    if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (m_own < 0 && Req[c]) begin
          m_own = c; m_first = 1; m_cnt = 0;
        end
      end
    end else begin
      w = Req[m_own];
      rel = 0;
      if (w) begin
        m_q = Data[m_own*W +: W];
        exp_ack[m_own] = 1'b1;
      end
      if (m_first) begin
        if (w && Lock[m_own]) begin
          m_first = 0; m_cnt = 1;
        end else rel = 1;
      end else begin
        m_cnt++;
        if (!Lock[m_own] || m_cnt >= MH) rel = 1;
      end
      if (rel) begin
        m_ptr = (m_own + 1) % N;
        m_own = -1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    Rst_l = 1'b0; Req = '0; Lock = '0; Data = '0;
    model_reset();
    #2;
    n_checks++;
    if ({Gnt, Ack, Q, Owner, Busy} !== 15'b0) begin
      n_fail++;
      $display("FAIL reset: got gnt=%b ack=%b q=%h own=%0d busy=%b want all 0",
               Gnt, Ack, Q, Owner, Busy);
    end
    @(negedge Clk);
    Rst_l = 1'b1;
  endtask

  task automatic test_single();
    Data = 16'h0A00; Req = 4'b0100;
    step();
    n_checks++;
    if (Gnt !== 4'b0100 || Busy !== 1'b1 || Ack !== 4'b0) begin
      n_fail++;
      $display("FAIL single_grant: gnt=%b busy=%b ack=%b want 0100/1/0000",
               Gnt, Busy, Ack);
    end
    step();
    n_checks++;
    if (Q !== 4'hA || Ack !== 4'b0100 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_write: q=%h ack=%b busy=%b want a/0100/0",
               Q, Ack, Busy);
    end
    Req = '0;
    step();
    Data = 16'h4321; Req = 4'b1111;
    step();
    n_checks++;
    if (Gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL single_ptr: gnt=%b want 1000", Gnt);
    end
    step();
    n_checks++;
    if (Ack !== 4'b1000 || Q !== 4'h4) begin
      n_fail++;
      $display("FAIL single_ptr_wr: ack=%b q=%h want 1000/4", Ack, Q);
    end
    Req = '0;
    step();
  endtask

  task automatic test_round_robin();
    int ai[$], aq[$], ac[$];
    int eo[5], eq[5];
    eo = '{0, 1, 2, 3, 0};
    eq = '{1, 2, 3, 4, 1};
    Data = 16'h4321; Req = 4'b1111;
    for (int s = 1; s <= 10; s++) begin
      step();
      n_checks++;
      if ({Gnt, Ack, Q, Busy} !== {m_gnt(), exp_ack, m_q, m_own >= 0}) begin
        n_fail++;
        $display("FAIL rr_cycle%0d: gnt=%b ack=%b q=%h busy=%b want %b %b %h %b",
                 s, Gnt, Ack, Q, Busy, m_gnt(), exp_ack, m_q, m_own >= 0);
      end
      for (int j = 0; j < N; j++)
        if (Ack[j] === 1'b1) begin
          ai.push_back(j); aq.push_back(int'(Q)); ac.push_back(s);
        end
    end
    n_checks++;
    if (ai.size() != 5) begin
      n_fail++;
      $display("FAIL rr_count: got %0d acks want 5", ai.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (ai[k] != eo[k] || aq[k] != eq[k] || ac[k] != 2*k+2) begin
          n_fail++;
          $display("FAIL rr_order%0d: idx=%0d q=%0d cyc=%0d want %0d %0d %0d",
                   k, ai[k], aq[k], ac[k], eo[k], eq[k], 2*k+2);
        end
      end
    end
    Req = '0;
    step();
  endtask

  task automatic test_lock_forced();
    int n1;
    n1 = 0;
    Data = 16'h9050; Req = 4'b1010; Lock = 4'b0010;
    step();
    n_checks++;
    if (Gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL lock_grant: gnt=%b want 0010", Gnt);
    end
    for (int s = 0; s < MH; s++) begin
      step();
      if (Ack === 4'b0010 && Q === 4'h5) n1++;
      n_checks++;
      if ({Gnt, Ack, Q, Busy} !== {m_gnt(), exp_ack, m_q, m_own >= 0}) begin
        n_fail++;
        $display("FAIL lock_cycle%0d: gnt=%b ack=%b q=%h busy=%b want %b %b %h %b",
                 s, Gnt, Ack, Q, Busy, m_gnt(), exp_ack, m_q, m_own >= 0);
      end
    end
    n_checks++;
    if (n1 != MH) begin
      n_fail++;
      $display("FAIL lock_acks: got %0d want %0d", n1, MH);
    end
    step();
    n_checks++;
    if (Ack !== 4'b0 || Gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL lock_release: ack=%b gnt=%b want 0000/1000", Ack, Gnt);
    end
    Req = 4'b1000; Lock = '0;
    step();
    n_checks++;
    if (Ack !== 4'b1000 || Q !== 4'h9) begin
      n_fail++;
      $display("FAIL lock_next: ack=%b q=%h want 1000/9", Ack, Q);
    end
    Req = '0;
    step();
  endtask

  task automatic test_idle_hold();
    Data = 16'h0007; Req = 4'b0001; Lock = 4'b0001;
    step();
    step();
    n_checks++;
    if (Ack !== 4'b0001 || Q !== 4'h7 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ih_write: ack=%b q=%h busy=%b want 0001/7/1", Ack, Q, Busy);
    end
    Req = '0;
    for (int s = 0; s < 2; s++) begin
      step();
      n_checks++;
      if (Ack !== 4'b0 || Q !== 4'h7 || Busy !== 1'b1) begin
        n_fail++;
        $display("FAIL ih_idle%0d: ack=%b q=%h busy=%b want 0000/7/1",
                 s, Ack, Q, Busy);
      end
    end
    Lock = '0;
    step();
    n_checks++;
    if (Busy !== 1'b0 || Ack !== 4'b0 || Q !== 4'h7 || Gnt !== 4'b0) begin
      n_fail++;
      $display("FAIL ih_exit: busy=%b ack=%b q=%h gnt=%b want 0/0000/7/0000",
               Busy, Ack, Q, Gnt);
    end
    Data = 16'h4321; Req = 4'b1111;
    step();
    n_checks++;
    if (Gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL ih_ptr: gnt=%b want 0010", Gnt);
    end
    step();
    Req = '0;
    step();
  endtask

  task automatic test_protocol();
    Data = 16'h0B00; Req = 4'b0100;
    step();
    n_checks++;
    if (Gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL pv_grant: gnt=%b want 0100", Gnt);
    end
    Req = '0;
    step();
    n_checks++;
    if (Ack !== 4'b0 || Q !== 4'h2 || Busy !== 1'b0 || Gnt !== 4'b0) begin
      n_fail++;
      $display("FAIL pv_drop: ack=%b q=%h busy=%b gnt=%b want 0000/2/0/0000",
               Ack, Q, Busy, Gnt);
    end
    Data = 16'h4321; Req = 4'b1111;
    step();
    n_checks++;
    if (Gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL pv_ptr: gnt=%b want 1000", Gnt);
    end
    step();
    Req = '0;
    step();
  endtask

  task automatic test_async_reset();
    Data = 16'h00D0; Req = 4'b0010; Lock = 4'b0010;
    step();
    step();
    step();
    n_checks++;
    if (Q !== 4'hD || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_pre: q=%h busy=%b want d/1", Q, Busy);
    end
    #3;
    Rst_l = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({Gnt, Ack, Q, Busy} !== 13'b0) begin
      n_fail++;
      $display("FAIL ar_clear: gnt=%b ack=%b q=%h busy=%b want all 0",
               Gnt, Ack, Q, Busy);
    end
    Req = '0; Lock = '0;
    @(negedge Clk);
    Rst_l = 1'b1;
    Data = 16'h4321; Req = 4'b1111;
    step();
    n_checks++;
    if (Gnt !== 4'b0001 || Owner !== 2'd0) begin
      n_fail++;
      $display("FAIL ar_first: gnt=%b own=%0d want 0001/0", Gnt, Owner);
    end
    step();
    n_checks++;
    if (Ack !== 4'b0001 || Q !== 4'h1) begin
      n_fail++;
      $display("FAIL ar_write: ack=%b q=%h want 0001/1", Ack, Q);
    end
    Req = '0;
    step();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int s = 0; s < 600; s++) begin
      step();
      n_checks++;
      if ({Gnt, Ack, Q, Busy} !== {m_gnt(), exp_ack, m_q, m_own >= 0} ||
          (m_own >= 0 && Owner !== 2'(m_own))) begin
        n_fail++;
        if (bad++ < 10)
          $display("FAIL rand_cycle%0d: gnt=%b ack=%b q=%h busy=%b own=%0d want %b %b %h %b %0d",
                   s, Gnt, Ack, Q, Busy, Owner, m_gnt(), exp_ack, m_q,
                   m_own >= 0, m_own);
      end
      for (int i = 0; i < N; i++) begin
        if (Req[i]) begin
          if (Ack[i] && $urandom_range(1, 0) == 1) Req[i] = 1'b0;
          else if ($urandom_range(49, 0) == 0) Req[i] = 1'b0;
        end else if ($urandom_range(3, 0) == 0) begin
          Data[i*W +: W] = 4'($urandom);
          Req[i] = 1'b1;
        end
        if ($urandom_range(3, 0) == 0) Lock[i] = ~Lock[i];
      end
    end
    Req = '0; Lock = '0;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock_forced();
    test_idle_hold();
    test_protocol();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
